// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - FSM state encoding and sizing helpers for chunked_seq_adder
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit slice adder, reports carry into its MSB
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = full[CHUNK-1:0];
  assign cout  = full[CHUNK];
  // Carry into the MSB recovered from the MSB sum bit; works for CHUNK=1 as well.
  assign c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle sliced adder/subtractor; ADDER_SAT_EN enables signed saturation
module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oOverflow,
  output logic             oBusy,
  output logic             oDone
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] aShift;
  logic [WIDTH-1:0] bShift;
  logic             carry;
  logic [CHUNK-1:0] sliceSum;
  logic             sliceCout;
  logic             sliceCmsb;
  logic             accept;
  logic             lastSlice;

  assign accept    = (state == ST_IDLE) && iStart;
  assign lastSlice = (state == ST_RUN) && (idx == LAST_IDX);

  // Operands shift right so the active slice always sits in the low CHUNK bits.
  chunk_adder #(.CHUNK(CHUNK)) uSlice (
    .a    (aShift[CHUNK-1:0]),
    .b    (bShift[CHUNK-1:0]),
    .cin  (carry),
    .sum  (sliceSum),
    .cout (sliceCout),
    .c_msb(sliceCmsb)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= ST_IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (iStart) nextState = ST_RUN;
      ST_RUN:  if (idx == LAST_IDX) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    oBusy = 1'b0;
    oDone = 1'b0;
    case (state)
      ST_RUN:  oBusy = 1'b1;
      ST_DONE: begin
        oBusy = 1'b1;
        oDone = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      aShift    <= '0;
      bShift    <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      oData     <= '0;
      oData_C   <= 1'b0;
      oOverflow <= 1'b0;
    end else if (accept) begin
      aShift <= iData_a;
      bShift <= iData_b ^ {WIDTH{iSub}};
      carry  <= iSub | iC;
      idx    <= '0;
      oData  <= '0;
    end else if (state == ST_RUN) begin
      oData[int'(idx) * CHUNK +: CHUNK] <= sliceSum;
      aShift <= aShift >> CHUNK;
      bShift <= bShift >> CHUNK;
      carry  <= sliceCout;
      idx    <= idx + IDXW'(1);
      if (lastSlice) begin
        oData_C   <= sliceCout;
        oOverflow <= sliceCout ^ sliceCmsb;
`ifdef ADDER_SAT_EN
        // aShift low slice holds A's top slice here, so its MSB is A's sign.
        if (sliceCout ^ sliceCmsb)
          oData <= aShift[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - randomized self-checking bench for chunked_seq_adder
module tb_chunked_seq_adder;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] dataA = '0;
  logic [15:0] dataB = '0;
  logic        cIn = 1'b0;
  logic [15:0] data;
  logic        dataC;
  logic        ovf;
  logic        busy;
  logic        done;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  d8;
  logic        c8;
  logic        ov8;
  logic        busy8;
  logic        done8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .iClk(clk), .iRst_n(rstN), .iStart(start), .iSub(sub),
    .iData_a(dataA), .iData_b(dataB), .iC(cIn),
    .oData(data), .oData_C(dataC), .oOverflow(ovf), .oBusy(busy), .oDone(done)
  );

  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .iClk(clk), .iRst_n(rstN), .iStart(start8), .iSub(1'b0),
    .iData_a(a8), .iData_b(b8), .iC(1'b0),
    .oData(d8), .oData_C(c8), .oOverflow(ov8), .oBusy(busy8), .oDone(done8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, carry, result} from plain wide arithmetic.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
    logic [15:0] bb;
    logic [16:0] full;
    logic [15:0] d;
    logic        ov;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : c)};
    d    = full[15:0];
    ov   = (a[15] == bb[15]) && (d[15] != a[15]);
`ifdef ADDER_SAT_EN
    if (ov) d = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {ov, full[16], d};
  endfunction

  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input bit poke);
    logic [17:0] exp;
    int edges;
    bit seen;
    exp = model16(a, b, c, s);
    @(negedge clk);
    start = 1'b1; dataA = a; dataB = b; cIn = c; sub = s;
    @(posedge clk);
    edges = 1;
    seen = 0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    for (int k = 0; k < 40 && !seen; k++) begin
      dataA = 16'($urandom); dataB = 16'($urandom);
      cIn = 1'($urandom); sub = 1'($urandom);
      start = (poke && edges == 2);
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".busyRun"}, busy, 1);
      if (done) seen = 1;
    end
    chk({tag, ".doneSeen"}, seen, 1);
    chk({tag, ".latency"}, edges, 5);
    chk({tag, ".data"}, data, exp[15:0]);
    chk({tag, ".carry"}, dataC, exp[16]);
    chk({tag, ".ovf"}, ovf, exp[17]);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".donePulse"}, done, 0);
    chk({tag, ".busyIdle"}, busy, 0);
    chk({tag, ".dataHold"}, data, exp[15:0]);
  endtask

  initial begin
    int edges;
    bit seen;
    #1 rstN = 1'b0;
    #2;
    chk("rst.data", data, 0);
    chk("rst.carry", dataC, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.data8", d8, 0);
    @(negedge clk);
    rstN = 1'b1;

    runOp("c1", 16'h000F, 16'h0001, 1'b0, 1'b0, 0);
    runOp("c2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    runOp("c2b", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
    runOp("c3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    runOp("c3b", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 0);
    runOp("c4a", 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    runOp("c4b", 16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    runOp("c5", 16'h1234, 16'h1111, 1'b0, 1'b0, 1);

    // Reset in the middle of a run: partial result must vanish, no oDone.
    @(negedge clk);
    start = 1'b1; dataA = 16'h1234; dataB = 16'h4321; cIn = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    chk("midRst.data", data, 0);
    chk("midRst.busy", busy, 0);
    chk("midRst.done", done, 0);
    chk("midRst.carry", dataC, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midRst.noDone", done, 0);
    end
    rstN = 1'b1;
    runOp("postRst", 16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 5 == 0) ra = {ra[15], {15{~ra[15]}}};
      runOp($sformatf("rnd%0d", n), ra, rb, 1'($urandom), 1'($urandom), (n % 7 == 3));
    end

    // Single-slice instance: RUN lasts one cycle.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01;
    @(posedge clk);
    edges = 1;
    seen = 0;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done8) seen = 1;
    end
    chk("w8.doneSeen", seen, 1);
    chk("w8.latency", edges, 2);
    chk("w8.data", d8, 8'h10);
    chk("w8.carry", c8, 0);
    chk("w8.ovf", ov8, 0);
    @(negedge clk);
    chk("w8.busyIdle", busy8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
